// File: rtl/jt51_expgen.sv
// Log-to-linear converter: 3-stage pipeline (ROM read, octave shift, sign apply).
// Define JT51_EXPGEN_SIGN_EN to enable output negation from in_sign.
module jt51_expgen #(
    parameter int MW  = 8,
    parameter int EW  = 4,
    parameter int OW  = 13,
    parameter int CHW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              in_valid,
    input  logic [EW+MW-1:0]  in_att,
    input  logic              in_sign,
    input  logic [CHW-1:0]    in_ch,
    output logic              out_valid,
    output logic [OW:0]       out_lin,
    output logic [CHW-1:0]    out_ch
);

    typedef logic [OW-1:0] rom_t [2**MW];

    // Entry i = min(2^OW-1, round-half-up(2^OW * 2^(-i/2^MW)))
    function automatic rom_t build_rom();
        rom_t r;
        real  v;
        int   t;
        for (int unsigned i = 0; i < 2**MW; i++) begin
            v = (2.0 ** OW) * (2.0 ** (-real'(i) / (2.0 ** MW)));
            t = $rtoi(v + 0.5);
            if (t > 2**OW - 1) t = 2**OW - 1;
            r[i[MW-1:0]] = OW'(t);
        end
        return r;
    endfunction

    localparam rom_t ROM = build_rom();

    logic              s1_valid;
    logic [CHW-1:0]    s1_ch;
    logic [EW-1:0]     s1_oct;
    logic [OW-1:0]     s1_tbl;
    logic              s2_valid;
    logic [CHW-1:0]    s2_ch;
    logic [OW-1:0]     s2_mag;
    logic [OW-1:0]     mag_d;
    logic [OW:0]       lin_d;

    always_comb begin
        mag_d = '0;
        if (32'(s1_oct) < OW) mag_d = s1_tbl >> s1_oct;
    end

`ifdef JT51_EXPGEN_SIGN_EN
    logic s1_sign;
    logic s2_sign;

    always_comb begin
        lin_d = {1'b0, s2_mag};
        if (s2_sign) lin_d = -{1'b0, s2_mag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign <= 1'b0;
            s2_sign <= 1'b0;
        end else if (cen) begin
            s1_sign <= in_sign;
            s2_sign <= s1_sign;
        end
    end
`else
    logic unused_sign;
    assign unused_sign = in_sign;

    always_comb begin
        lin_d = {1'b0, s2_mag};
    end
`endif

    // Data registers follow the pipeline regardless of valid; valid only qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_oct    <= '0;
            s1_tbl    <= '0;
            s2_valid  <= 1'b0;
            s2_ch     <= '0;
            s2_mag    <= '0;
            out_valid <= 1'b0;
            out_lin   <= '0;
            out_ch    <= '0;
        end else if (cen) begin
            s1_valid  <= in_valid;
            s1_ch     <= in_ch;
            s1_oct    <= in_att[EW+MW-1:MW];
            s1_tbl    <= ROM[in_att[MW-1:0]];
            s2_valid  <= s1_valid;
            s2_ch     <= s1_ch;
            s2_mag    <= mag_d;
            out_valid <= s2_valid;
            out_lin   <= lin_d;
            out_ch    <= s2_ch;
        end
    end

endmodule

// File: tb/tb_jt51_expgen.sv
// Directed self-checking bench for jt51_expgen (MW=8, EW=4, OW=13, CHW=3).
// Expected sign behaviour follows whether JT51_EXPGEN_SIGN_EN is defined.
module tb_jt51_expgen;

`ifdef JT51_EXPGEN_SIGN_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic        in_valid;
    logic [11:0] in_att;
    logic        in_sign;
    logic [2:0]  in_ch;
    logic        out_valid;
    logic [13:0] out_lin;
    logic [2:0]  out_ch;

    int tests;
    int fails;

    logic        m_v   [3];
    logic [13:0] m_lin [3];
    logic [2:0]  m_ch  [3];

    jt51_expgen #(
        .MW  (8),
        .EW  (4),
        .OW  (13),
        .CHW (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .in_valid  (in_valid),
        .in_att    (in_att),
        .in_sign   (in_sign),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_lin   (out_lin),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] model_lin(logic [11:0] att, logic sgn);
        real v;
        int  t;
        int  mag;
        v = 8192.0 * (2.0 ** (-real'(att[7:0]) / 256.0));
        t = int'($floor(v + 0.5));
        if (t > 8191) t = 8191;
        if (att[11:8] >= 4'd13) mag = 0;
        else mag = t >> att[11:8];
        if (SIGN_EN && sgn) mag = -mag;
        return 14'(mag);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i]   = 1'b0;
            m_lin[i] = '0;
            m_ch[i]  = '0;
        end
    endtask

    // One clock edge, then advance the reference pipeline with the inputs that edge saw.
    task automatic step();
        @(posedge clk);
        if (cen && rst_n) begin
            m_v[2]   = m_v[1];   m_lin[2] = m_lin[1]; m_ch[2] = m_ch[1];
            m_v[1]   = m_v[0];   m_lin[1] = m_lin[0]; m_ch[1] = m_ch[0];
            m_v[0]   = in_valid;
            m_lin[0] = model_lin(in_att, in_sign);
            m_ch[0]  = in_ch;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        cen      = 1'b1;
        in_valid = 1'b1;
        in_att   = 12'h000;
        in_sign  = 1'b1;
        in_ch    = 3'd7;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) cen = 1'b0;
            tests++;
            if (out_valid !== 1'b0 || out_lin !== 14'd0 || out_ch !== 3'd0) begin
                fails++;
                $display("FAIL reset_hold: valid=%b lin=%0d ch=%0d, required 0/0/0",
                         out_valid, out_lin, out_ch);
            end
        end
        in_valid = 1'b0;
        cen      = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [11:0] att  [8] = '{12'h000, 12'h080, 12'h100, 12'hD00, 12'hD00, 12'hC00, 12'h0FF, 12'hFFF};
        logic        sgn  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  ch   [8] = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0};
        int          mag  [8] = '{8191, 5793, 4095, 0, 0, 1, 4107, 0};
        logic [13:0] exp_lin;
        for (int k = 0; k < 8; k++) begin
            exp_lin  = (SIGN_EN && sgn[k]) ? 14'(-mag[k]) : 14'(mag[k]);
            in_valid = 1'b1;
            in_att   = att[k];
            in_sign  = sgn[k];
            in_ch    = ch[k];
            step();
            in_valid = 1'b0;
            in_att   = 12'hA5A;
            in_ch    = 3'd3;
            step();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL directed_early[%0d]: valid=%b, required 0", k, out_valid);
            end
            step();
            tests++;
            if (out_valid !== 1'b1 || out_lin !== exp_lin || out_ch !== ch[k]) begin
                fails++;
                $display("FAIL directed[%0d] att=%h: valid=%b lin=%0d ch=%0d, required 1/%0d/%0d",
                         k, att[k], out_valid, $signed(out_lin), out_ch, $signed(exp_lin), ch[k]);
            end
        end
        step();
        step();
    endtask

    task automatic test_stream();
        cen = 1'b1;
        for (int n = 0; n < 4096 + 3; n++) begin
            if (n < 4096) begin
                in_valid = 1'b1;
                in_att   = 12'(n);
                in_sign  = n[0] ^ n[5];
                in_ch    = 3'(n % 8);
            end else begin
                in_valid = 1'b0;
            end
            step();
            tests++;
            if (out_valid !== m_v[2]) begin
                fails++;
                $display("FAIL stream_valid n=%0d: valid=%b, required %b", n, out_valid, m_v[2]);
            end else if (m_v[2] && (out_lin !== m_lin[2] || out_ch !== m_ch[2])) begin
                fails++;
                $display("FAIL stream_data n=%0d: lin=%0d ch=%0d, required %0d/%0d",
                         n, $signed(out_lin), out_ch, $signed(m_lin[2]), m_ch[2]);
            end
            if (n >= 2 && n < 4098) begin
                tests++;
                if (out_valid !== 1'b1 || out_ch !== 3'((n - 2) % 8)) begin
                    fails++;
                    $display("FAIL stream_order n=%0d: valid=%b ch=%0d, required 1/%0d",
                             n, out_valid, out_ch, (n - 2) % 8);
                end
            end
        end
    endtask

    task automatic test_cen_toggle();
        int          j;
        logic [13:0] prev_lin;
        logic        prev_v;
        j = 0;
        for (int c = 0; c < 900; c++) begin
            prev_lin = out_lin;
            prev_v   = out_valid;
            cen = (c % 3 == 0);
            if (cen) begin
                in_valid = (j < 290);
                in_att   = 12'((j * 14 + 3) % 4096);
                in_sign  = j[1];
                in_ch    = 3'(j % 8);
                j++;
            end else begin
                in_valid = 1'($urandom);
                in_att   = 12'($urandom);
                in_sign  = 1'($urandom);
                in_ch    = 3'($urandom);
            end
            step();
            tests++;
            if (out_valid !== m_v[2] || (m_v[2] && (out_lin !== m_lin[2] || out_ch !== m_ch[2]))) begin
                fails++;
                $display("FAIL cen_stream c=%0d: valid=%b lin=%0d ch=%0d, required %b/%0d/%0d",
                         c, out_valid, $signed(out_lin), out_ch, m_v[2], $signed(m_lin[2]), m_ch[2]);
            end
            if (!cen) begin
                tests++;
                if (out_valid !== prev_v || out_lin !== prev_lin) begin
                    fails++;
                    $display("FAIL cen_hold c=%0d: valid=%b lin=%0d, required %b/%0d",
                             c, out_valid, $signed(out_lin), prev_v, $signed(prev_lin));
                end
            end
        end
        cen = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp_lin;
        cen = 1'b1;
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'b1;
            in_att   = 12'(n * 37);
            in_sign  = 1'b0;
            in_ch    = 3'(n);
            step();
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_lin !== 14'd0 || out_ch !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_async: valid=%b lin=%0d ch=%0d, required 0/0/0",
                     out_valid, out_lin, out_ch);
        end
        rst_n = 1'b1;
        model_clear();
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_flush n=%0d: valid=%b, required 0", n, out_valid);
            end
        end
        in_valid = 1'b1;
        in_att   = 12'h080;
        in_sign  = 1'b1;
        in_ch    = 3'd2;
        exp_lin  = SIGN_EN ? 14'(-5793) : 14'd5793;
        step();
        in_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            step();
            tests++;
            if (n == 0 && out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_latency: valid=%b, required 0", out_valid);
            end
            if (n == 1 && (out_valid !== 1'b1 || out_lin !== exp_lin || out_ch !== 3'd2)) begin
                fails++;
                $display("FAIL reset_mid_first: valid=%b lin=%0d ch=%0d, required 1/%0d/2",
                         out_valid, $signed(out_lin), out_ch, $signed(exp_lin));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_stream();
        test_cen_toggle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
